pong_match_ctrl: RTL
====================

Name: pong_match_ctrl

Overview:
- Match-level controller directly downstream of the ball stage.
- Consumes the ball's one-cycle left/right score pulses and keeps per-player points.
- Drives the ball's start, reset and animate inputs, sequencing each round through a timed serve.
- Detects match end and presents BCD score digits for the seven-segment display and the overlay renderer.

Parameters:
- WIN_SCORE, 7, points needed to win; legal 1..15.
- SERVE_DELAY, 120, animation strobes between a point (or match start) and the next serve; 0 = serve on the next cycle; fits 8 bits.

Ports:
- in_clock  input  1  base clock
- in_reset_n  input  1  asynchronous, active-low reset
- in_ani_stb  input  1  animation strobe, one cycle per frame
- in_button_start  input  1  raw start button, active-high, asynchronous to in_clock
- in_left_score  input  1  one-cycle pulse: left player scored
- in_right_score  input  1  one-cycle pulse: right player scored
- out_start  output  1  one-cycle pulse to ball in_start
- out_ball_reset  output  1  one-cycle pulse to ball in_reset (active-high)
- out_animate  output  1  level to ball in_animate
- out_left_points  output  4  left score, binary
- out_right_points  output  4  right score, binary
- out_left_bcd  output  8  {tens, ones} BCD of out_left_points
- out_right_bcd  output  8  {tens, ones} BCD of out_right_points
- out_winner  output  2  00 none, 01 left, 10 right, 11 draw
- out_state  output  2  00 IDLE, 01 SERVE_WAIT, 10 PLAY, 11 GAME_OVER

Behaviour:
- Reset (in_reset_n=0, asynchronous) forces:
  - state IDLE; all points 0; winner 00
  - out_start, out_ball_reset, out_animate = 0
  - serve counter 0; synchroniser and edge-detect flops 0
- Button path: 2-flop synchroniser, then rising-edge detect. A "press" is a one-cycle internal event, 3 cycles after the synchronous rise.
- IDLE (out_animate=0):
  - On press: clear both points, clear winner, pulse out_ball_reset, load counter with SERVE_DELAY, go to SERVE_WAIT.
- SERVE_WAIT (out_animate=1; the ball is stopped and ignores this):
  - Each in_ani_stb decrements the counter if it is non-zero.
  - In any cycle with counter==0: pulse out_start for exactly one cycle, go to PLAY.
  - Total wait is SERVE_DELAY strobes.
- PLAY (out_animate=1), on any score pulse:
  - Increment the respective points; both are incremented if both pulses arrive in the same cycle.
  - Registered points are visible the cycle after the pulse.
  - If either new value equals WIN_SCORE, go to GAME_OVER. out_winner = 01, 10, or 11 if both reach WIN_SCORE simultaneously.
  - Otherwise reload the counter with SERVE_DELAY and go to SERVE_WAIT.
- GAME_OVER (out_animate=0):
  - Points and winner are held.
  - A press behaves as in IDLE and starts a new match.
- Ignored events:
  - Score pulses outside PLAY.
  - Presses in SERVE_WAIT or PLAY.
  - in_ani_stb outside SERVE_WAIT has no effect.
- Points never exceed WIN_SCORE; no wrap is possible.
- BCD outputs:
  - Combinational from the registered points: tens = (p>=10), ones = p - 10*tens.
  - Upper 3 bits of the tens nibble are always 0.
- out_start and out_ball_reset are registered, never high for more than one consecutive cycle, and never high in the same cycle.
- out_state encodes the current registered state.

Test Plan:
- Reset then press: after the press is detected, out_ball_reset is high for 1 cycle, state=01. With SERVE_DELAY=3, out_start pulses after the 3rd in_ani_stb, then state=10.
- In PLAY, one in_left_score pulse: out_left_points=1 the next cycle, state returns to 01, out_start fires again after 3 strobes.
- WIN_SCORE=7, left at 6, in_left_score pulse: state=11, out_winner=01, out_animate=0. Further score pulses leave points at 7/x.
- WIN_SCORE=12, both at 11, simultaneous left and right pulses: points 12/12, out_winner=11, out_left_bcd=8'h12.
- Presses during PLAY and score pulses during SERVE_WAIT: no change to state or points. A press in GAME_OVER clears points to 0, winner to 00, and pulses out_ball_reset.
- Assert in_reset_n low mid-SERVE_WAIT, between clock edges: all outputs reach reset values immediately; state=00 with no out_start pulse after release.

Source files
------------

// File: rtl/pong_match_ctrl.sv
// Match controller for the pong ball stage: keeps per-player points, sequences
// each round through a timed serve, detects the match end and presents BCD digits.
module pong_match_ctrl #(
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned SERVE_DELAY = 120
) (
  input  logic       in_clock,
  input  logic       in_reset_n,
  input  logic       in_ani_stb,
  input  logic       in_button_start,
  input  logic       in_left_score,
  input  logic       in_right_score,
  output logic       out_start,
  output logic       out_ball_reset,
  output logic       out_animate,
  output logic [3:0] out_left_points,
  output logic [3:0] out_right_points,
  output logic [7:0] out_left_bcd,
  output logic [7:0] out_right_bcd,
  output logic [1:0] out_winner,
  output logic [1:0] out_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SERVE = 2'b01,
    ST_PLAY  = 2'b10,
    ST_OVER  = 2'b11
  } state_e;

  localparam logic [3:0] WIN_PTS   = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_CNT = 8'(SERVE_DELAY);

  function automatic logic [7:0] to_bcd(input logic [3:0] p);
    logic [7:0] r;
    if (p >= 4'd10) begin
      r = {4'b0001, p - 4'd10};
    end else begin
      r = {4'b0000, p};
    end
    return r;
  endfunction

  logic       btn_meta_q, btn_sync_q, btn_prev_q, press_q;
  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] left_q, left_d, right_q, right_d;
  logic [3:0] left_sum_s, right_sum_s;
  logic [1:0] winner_q, winner_d;
  logic       start_q, start_d;
  logic       ball_rst_q, ball_rst_d;
  logic       animate_q, animate_d;

  // Button synchroniser, edge detector and registered press event
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      btn_prev_q <= 1'b0;
      press_q    <= 1'b0;
    end else begin
      btn_meta_q <= in_button_start;
      btn_sync_q <= btn_meta_q;
      btn_prev_q <= btn_sync_q;
      press_q    <= btn_sync_q & ~btn_prev_q;
    end
  end

  // Match state, serve counter, points and registered ball controls
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      left_q     <= 4'd0;
      right_q    <= 4'd0;
      winner_q   <= 2'b00;
      start_q    <= 1'b0;
      ball_rst_q <= 1'b0;
      animate_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      left_q     <= left_d;
      right_q    <= right_d;
      winner_q   <= winner_d;
      start_q    <= start_d;
      ball_rst_q <= ball_rst_d;
      animate_q  <= animate_d;
    end
  end

  assign left_sum_s  = left_q + {3'b000, in_left_score};
  assign right_sum_s = right_q + {3'b000, in_right_score};

  // Next-state logic; a point can never push past WIN_PTS because play stops there
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    left_d     = left_q;
    right_d    = right_q;
    winner_d   = winner_q;
    start_d    = 1'b0;
    ball_rst_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (press_q) begin
          left_d     = 4'd0;
          right_d    = 4'd0;
          winner_d   = 2'b00;
          ball_rst_d = 1'b1;
          cnt_d      = SERVE_CNT;
          state_d    = ST_SERVE;
        end else begin
          state_d = state_q;
        end
      end
      ST_SERVE: begin
        if (cnt_q == 8'd0) begin
          start_d = 1'b1;
          state_d = ST_PLAY;
        end else if (in_ani_stb) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_PLAY: begin
        if (in_left_score || in_right_score) begin
          left_d  = left_sum_s;
          right_d = right_sum_s;
          if ((left_sum_s == WIN_PTS) || (right_sum_s == WIN_PTS)) begin
            winner_d = {right_sum_s == WIN_PTS, left_sum_s == WIN_PTS};
            state_d  = ST_OVER;
          end else begin
            cnt_d   = SERVE_CNT;
            state_d = ST_SERVE;
          end
        end else begin
          state_d = ST_PLAY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    animate_d = (state_d == ST_SERVE) || (state_d == ST_PLAY);
  end

  assign out_start        = start_q;
  assign out_ball_reset   = ball_rst_q;
  assign out_animate      = animate_q;
  assign out_left_points  = left_q;
  assign out_right_points = right_q;
  assign out_left_bcd     = to_bcd(left_q);
  assign out_right_bcd    = to_bcd(right_q);
  assign out_winner       = winner_q;
  assign out_state        = state_q;

endmodule
